// File: rtl/twiddle_phase_seq.sv
// Twiddle phase sequencer: streams per-butterfly CORDIC input angles
// for one DIT FFT stage, PARL lanes per beat, in butterfly order.
module twiddle_phase_seq #(
  parameter int FFT_STAGE  = 3,
  parameter int LAST_STAGE = 8,
  parameter int PARL       = 1,
  parameter int PHASE_W    = 16,
  parameter int INVERSE    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cont,
  output logic               busy,
  output logic               tvalid,
  input  logic               tready,
  output logic               tlast,
  output logic [PHASE_W-1:0] phase [PARL]
);

  localparam int BEATS = (1 << (LAST_STAGE - 1)) / PARL;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam int SHIFT = PHASE_W - FFT_STAGE;
  localparam logic [PHASE_W-1:0] J_MASK =
    PHASE_W'((1 << (FFT_STAGE - 1)) - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   nxt_cnt;
  logic               hs;
  logic               at_last;
  logic               load;
  logic               stop;
  logic [PHASE_W-1:0] nxt_phase [PARL];

  // j << (PHASE_W - s) folds both the stage and the turn scaling
  function automatic logic [PHASE_W-1:0] lane_phase(
    input logic [PHASE_W-1:0] n
  );
    logic [PHASE_W-1:0] u;
    u = (n & J_MASK) << SHIFT;
    return (INVERSE != 0) ? u : (PHASE_W'(0) - u);
  endfunction

  always_comb begin
    hs      = tvalid & tready;
    at_last = (cnt == LAST_CNT);
    stop    = (state == RUN) & hs & at_last & ~cont;
    nxt_cnt = ((state == IDLE) || at_last) ? '0 : cnt + 1'b1;
    load    = (state == IDLE) ? start : (hs & (~at_last | cont));
    for (int l = 0; l < PARL; l++) begin
      nxt_phase[l] = lane_phase(PHASE_W'(nxt_cnt) * PHASE_W'(PARL)
                                + PHASE_W'(l));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
      busy   <= 1'b0;
      for (int l = 0; l < PARL; l++) phase[l] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            tvalid <= 1'b1;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state  <= IDLE;
            tvalid <= 1'b0;
            busy   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (load) begin
        cnt   <= nxt_cnt;
        tlast <= (nxt_cnt == LAST_CNT);
        phase <= nxt_phase;
      end else if (stop) begin
        cnt   <= '0;
        tlast <= 1'b0;
        for (int l = 0; l < PARL; l++) phase[l] <= '0;
      end
    end
  end

endmodule
